y86_seq_controller: RTL and testbench

- Multi-cycle sequencer for the Y86-64 SEQ datapath (fetch, decode, execute, data memory, write-back, PC update).
- Sequences one instruction at a time through the stages and issues single-cycle latch strobes.
- Runs the instruction-memory and data-memory request/acknowledge handshakes.
- Gates the register-file and condition-code writes, and owns the architectural status code.

---
 rtl/y86_seq_controller.sv | 187 ++++++++++++++++++
 tb/tb_y86_seq_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_controller.sv
// Stage sequencer for the Y86-64 SEQ datapath: fetch/decode/execute/memory/write-back/PC, memory handshakes, status code.
// Optional macro PERF_COUNTERS_EN builds the busy-cycle and retired-instruction counters; otherwise they read as zero.
module y86_seq_controller #(
  parameter int TMO_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             cc_en,
  output logic             rf_we_e,
  output logic             rf_we_m,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRBACK, PCUPD, HALT, ERROR
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // One below all-ones: a missing ack in this cycle makes the count terminal.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state;
  logic [TMO_W-1:0] tmoCnt;
  logic             imemAck;
  logic             dmemAck;
  logic             tmoHit;
  logic             isMemOp;
  logic             writesValE;
  logic             writesValM;

  // Acks only count while the matching request is up.
  assign imemAck    = imem_req & imem_ack;
  assign dmemAck    = dmem_req & dmem_ack;
  assign tmoHit     = (tmoCnt == TMO_LAST);
  assign isMemOp    = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign writesValE = (icode inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ||
                      ((icode == 4'h2) && cnd);
  assign writesValM = icode inside {4'h5, 4'hB};

  assign f_en    = (state == FETCH) && imemAck;
  assign d_en    = (state == DECODE);
  assign e_en    = (state == EXECUTE);
  assign cc_en   = (state == EXECUTE) && (icode == 4'h6);
  assign m_en    = (state == MEMORY) && dmemAck && !dmem_error;
  assign rf_we_e = (state == WRBACK) && writesValE;
  assign rf_we_m = (state == WRBACK) && writesValM;
  assign pc_en   = (state == PCUPD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      stat     <= STAT_AOK;
      busy     <= 1'b0;
      tmoCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            tmoCnt   <= '0;
          end
        end
        FETCH: begin
          if (imemAck) begin
            imem_req <= 1'b0;
            if (imem_error) begin
              state <= ERROR;
              stat  <= STAT_ADR;
              busy  <= 1'b0;
            end else if (!instr_valid) begin
              state <= ERROR;
              stat  <= STAT_INS;
              busy  <= 1'b0;
            end else if (icode == 4'h0) begin
              state <= HALT;
              stat  <= STAT_HLT;
              busy  <= 1'b0;
            end else begin
              state <= DECODE;
            end
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
            if (tmoHit) begin
              state    <= ERROR;
              stat     <= STAT_ADR;
              imem_req <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          if (isMemOp) begin
            state    <= MEMORY;
            dmem_req <= 1'b1;
            tmoCnt   <= '0;
          end else begin
            state <= WRBACK;
          end
        end
        MEMORY: begin
          if (dmemAck) begin
            dmem_req <= 1'b0;
            if (dmem_error) begin
              state <= ERROR;
              stat  <= STAT_ADR;
              busy  <= 1'b0;
            end else begin
              state <= WRBACK;
            end
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
            if (tmoHit) begin
              state    <= ERROR;
              stat     <= STAT_ADR;
              dmem_req <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        WRBACK: state <= PCUPD;
        PCUPD: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          tmoCnt   <= '0;
        end
        HALT:  state <= HALT;
        ERROR: state <= ERROR;
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycleCnt;
  logic [CNT_W-1:0] instrCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt <= '0;
      instrCnt <= '0;
    end else begin
      if (busy)  cycleCnt <= cycleCnt + 1'b1;
      if (pc_en) instrCnt <= instrCnt + 1'b1;
    end
  end

  assign cycle_count = cycleCnt;
  assign instr_count = instrCnt;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_y86_seq_controller.sv
// Bench for y86_seq_controller: acts as both memories, runs directed and random instructions against a stage-timing model.
module tb_y86_seq_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic        dmem_error = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, f_en, d_en, e_en, m_en, cc_en, rf_we_e, rf_we_m, pc_en, busy;
  logic [2:0]  stat;
  logic [31:0] cycle_count, instr_count;

  y86_seq_controller #(.TMO_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .cnd(cnd),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .cc_en(cc_en),
    .rf_we_e(rf_we_e), .rf_we_m(rf_we_m), .pc_en(pc_en), .stat(stat), .busy(busy),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam int F = 7, D = 6, E = 5, CC = 4, M = 3, RE = 2, RM = 1, PC = 0;

  int nPass = 0, nChecks = 0;
  int iLat = 1, dLat = 1, iWait = 0, dWait = 0;
  bit dErr = 1'b0, spur = 1'b0;
  int busyTotal = 0, retired = 0;
  int obsCnt[8], obsAt[8], expCnt[8], expAt[8];
  int expCyc, expIReq, expDReq, expStat;

  task automatic check(input string tag, input int obs, input int exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Memory responders: ack on the Nth request cycle (N=0 never acks); stray acks while idle.
  task automatic stepCycle();
    @(negedge clk);
    if (imem_req) begin
      iWait++;
      imem_ack = (iLat != 0) && (iWait == iLat);
    end else begin
      iWait = 0;
      imem_ack = spur & 1'($urandom_range(0, 1));
    end
    if (dmem_req) begin
      dWait++;
      dmem_ack   = (dLat != 0) && (dWait == dLat);
      dmem_error = dErr;
    end else begin
      dWait = 0;
      dmem_ack   = spur & 1'($urandom_range(0, 1));
      dmem_error = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  task automatic setExp(input int k, input int at);
    expCnt[k] = 1;
    expAt[k]  = at;
  endtask

  // Reference: stage schedule from the instruction class and the memory latencies.
  task automatic model(input logic [3:0] ic, input bit c, input bit valid, input bit iErr);
    bit mem, we, wm;
    int t, dl;
    mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    we  = (ic inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) || (ic == 4'h2 && c);
    wm  = ic inside {4'h5, 4'hB};
    for (int k = 0; k < 8; k++) begin expCnt[k] = 0; expAt[k] = 0; end
    expDReq = 0;
    expStat = 1;
    if (iLat == 0 || iLat > 15) begin
      expCyc = 15; expIReq = 15; expStat = 3;
      return;
    end
    expIReq = iLat;
    expCyc  = iLat;
    setExp(F, iLat);
    if (iErr)        begin expStat = 3; return; end
    if (!valid)      begin expStat = 4; return; end
    if (ic == 4'h0)  begin expStat = 2; return; end
    setExp(D, iLat + 1);
    setExp(E, iLat + 2);
    if (ic == 4'h6) setExp(CC, iLat + 2);
    t = iLat + 2;
    if (mem) begin
      dl = (dLat == 0 || dLat > 15) ? 15 : dLat;
      expDReq = dl;
      t += dl;
      if (dLat == 0 || dLat > 15 || dErr) begin
        expCyc = t; expStat = 3;
        return;
      end
      setExp(M, t);
    end
    t++;
    if (we) setExp(RE, t);
    if (wm) setExp(RM, t);
    t++;
    setExp(PC, t);
    expCyc = t;
  endtask

  task automatic runInstr(input logic [3:0] ic, input bit c, input bit valid, input bit iErr, input string tag);
    int cyc = 0, iReqC = 0, dReqC = 0;
    bit done = 1'b0;
    logic [7:0] sv;
    icode = ic; cnd = c; instr_valid = valid; imem_error = iErr;
    for (int k = 0; k < 8; k++) begin obsCnt[k] = 0; obsAt[k] = 0; end
    while (!done && cyc < 200) begin
      stepCycle();
      if (!busy) done = 1'b1;
      else begin
        cyc++;
        iReqC += int'(imem_req);
        dReqC += int'(dmem_req);
        sv = {f_en, d_en, e_en, cc_en, m_en, rf_we_e, rf_we_m, pc_en};
        for (int k = 0; k < 8; k++)
          if (sv[k]) begin obsCnt[k]++; obsAt[k] = cyc; end
        if (pc_en) done = 1'b1;
      end
    end
    check({tag, "_done"}, int'(done), 1);
    model(ic, c, valid, iErr);
    check({tag, "_cycles"}, cyc, expCyc);
    check({tag, "_imemReqCycles"}, iReqC, expIReq);
    check({tag, "_dmemReqCycles"}, dReqC, expDReq);
    check({tag, "_stat"}, int'(stat), expStat);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_strobe%0d_count", tag, k), obsCnt[k], expCnt[k]);
      check($sformatf("%s_strobe%0d_cycle", tag, k), obsAt[k], expAt[k]);
    end
    if (expStat != 1) begin
      check({tag, "_reqsDropped"}, int'({imem_req, dmem_req}), 0);
      check({tag, "_busyLow"}, int'(busy), 0);
    end
    busyTotal += expCyc;
    retired   += expCnt[PC];
  endtask

  task automatic startProgram();
    @(negedge clk);
    start = 1'b1;
    iWait = 0; dWait = 0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_stat", int'(stat), 1);
    check("reset_outputs", int'({imem_req, dmem_req, busy, f_en, d_en, e_en, m_en, pc_en}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    busyTotal = 0; retired = 0;
    iLat = 1; dLat = 1; dErr = 1'b0;
  endtask

  task automatic checkCounters(input string tag);
`ifdef PERF_COUNTERS_EN
    check({tag, "_cycleCount"}, int'(cycle_count), busyTotal);
    check({tag, "_instrCount"}, int'(instr_count), retired);
`else
    check({tag, "_cycleCount"}, int'(cycle_count), 0);
    check({tag, "_instrCount"}, int'(instr_count), 0);
`endif
  endtask

  initial begin
    int reqSeen;
    bit found;
    #12;
    check("por_stat", int'(stat), 1);
    check("por_outputs", int'({imem_req, dmem_req, busy, f_en, d_en, e_en, cc_en, m_en, rf_we_e, rf_we_m, pc_en}), 0);
    check("por_counters", int'(cycle_count | instr_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) stepCycle();
    check("idle_no_start", int'({imem_req, busy}), 0);

    // Directed program: stage timing per instruction class.
    startProgram();
    iLat = 1;             runInstr(4'h3, 1'b0, 1'b1, 1'b0, "irmovq");
    dLat = 3;             runInstr(4'h5, 1'b0, 1'b1, 1'b0, "mrmovq");
    iLat = 2;             runInstr(4'h2, 1'b0, 1'b1, 1'b0, "cmov_cnd0");
                          runInstr(4'h2, 1'b1, 1'b1, 1'b0, "cmov_cnd1");
    iLat = 1;             runInstr(4'h6, 1'b1, 1'b1, 1'b0, "opq");
    iLat = 15;            runInstr(4'h1, 1'b0, 1'b1, 1'b0, "nop_ackAtLimit");
    iLat = 1; dLat = 15;  runInstr(4'hB, 1'b0, 1'b1, 1'b0, "popq_ackAtLimit");

    // Random instructions with stray acks on the idle channel.
    spur = 1'b1;
    for (int n = 0; n < 40; n++) begin
      iLat = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(1, 4));
      dLat = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(1, 4));
      runInstr(4'($urandom_range(1, 11)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, $sformatf("rnd%0d", n));
    end
    spur = 1'b0;
    iLat = 1;
    runInstr(4'h0, 1'b0, 1'b1, 1'b0, "halt_after_random");
    checkCounters("random_program");

    // Halt is terminal: start and time do not restart fetch.
    reqSeen = 0;
    start = 1'b1;
    repeat (5) begin stepCycle(); reqSeen += int'(imem_req); end
    start = 1'b0;
    check("halt_no_imem_req", reqSeen, 0);
    check("halt_stat_held", int'(stat), 2);
    check("halt_busy", int'(busy), 0);

    // Two nops then halt: 11 busy cycles, 2 retired.
    doReset();
    startProgram();
    iLat = 1;
    runInstr(4'h1, 1'b0, 1'b1, 1'b0, "nop1");
    runInstr(4'h1, 1'b0, 1'b1, 1'b0, "nop2");
    runInstr(4'h0, 1'b0, 1'b1, 1'b0, "halt");
`ifdef PERF_COUNTERS_EN
    check("nops_cycleCount", int'(cycle_count), 11);
    check("nops_instrCount", int'(instr_count), 2);
`else
    check("nops_counters_tied", int'(cycle_count | instr_count), 0);
`endif

    doReset(); startProgram();
    dLat = 0;                 runInstr(4'h5, 1'b0, 1'b1, 1'b0, "dmem_timeout");
    doReset(); startProgram();
    dLat = 2; dErr = 1'b1;    runInstr(4'h5, 1'b0, 1'b1, 1'b0, "dmem_error");
    doReset(); startProgram();
    runInstr(4'h1, 1'b0, 1'b0, 1'b0, "invalid_instr");
    doReset(); startProgram();
    runInstr(4'h1, 1'b0, 1'b1, 1'b1, "imem_error");
    doReset(); startProgram();
    iLat = 0;                 runInstr(4'h1, 1'b0, 1'b1, 1'b0, "imem_timeout");
    checkCounters("imem_timeout");

    // Asynchronous reset in the middle of a data-memory wait.
    doReset(); startProgram();
    icode = 4'h5; dLat = 0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin stepCycle(); found = dmem_req; end
    check("midmem_reached", int'(found), 1);
    stepCycle(); stepCycle();
    dmem_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midmem_reqs", int'({imem_req, dmem_req}), 0);
    check("midmem_stat", int'(stat), 1);
    check("midmem_busy", int'(busy), 0);
    check("midmem_strobes", int'({m_en, rf_we_m, pc_en}), 0);
    check("midmem_counters", int'(cycle_count | instr_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    busyTotal = 0; retired = 0;
    repeat (2) stepCycle();
    check("postreset_idle", int'({imem_req, dmem_req, busy}), 0);
    startProgram();
    iLat = 1; dLat = 2;
    runInstr(4'h1, 1'b0, 1'b1, 1'b0, "postreset_nop");
    checkCounters("postreset");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
